result_serializer: RTL and testbench
====================================

# result_serializer

Parametrised successor to the fixed two-word output loader. Captures `NUM_WORDS` result words of `WORD_W` bits plus a mode tag on a start strobe, then streams them over an `OUT_W`-bit pin bus as a framed packet: sync, header, payload MSB-first, optional XOR checksum. Each symbol is held for a programmable number of cycles so slow off-chip samplers can follow. It sits between the eigen core (kappa, inv_kappa, regime) and `uo_out`.

## Interface
- `WORD_W`, 32: width of each result word; must be a multiple of `OUT_W`
- `NUM_WORDS`, 2: words per frame, at least 1
- `OUT_W`, 8: output bus width
- `MODE_W`, 3: mode tag width, at most `OUT_W`
- `HOLD_CYCLES`, 1: cycles each symbol is held, at least 1
- `CHECKSUM_EN`, 1: 1 appends the XOR checksum symbol
- `SYNC_SYM`, 8'hA5: first symbol of every frame
- `clk` in 1: the single clock; all state changes on its rising edge
- `rst_n` in 1: reset, asynchronous assertion, active-low
- `ena` in 1: 0 stalls all state
- `start` in 1: frame request
- `mode` in `MODE_W`: tag, captured at start
- `words` in `NUM_WORDS*WORD_W`: packed payload, word 0 in LSBs, captured at start
- `busy` out 1: frame in progress
- `out_sym` out `OUT_W`: current symbol
- `out_valid` out 1: `out_sym` is a frame symbol
- `frame_first` out 1: high while the sync symbol is presented
- `done` out 1: 1-cycle pulse after the last symbol
- `err_drop` out 1: sticky; a start arrived while busy

## Operation
- FSM states: IDLE, SYNC, HDR, DATA, CSUM.
  - IDLE to SYNC on `start` & `ena`.
  - SYNC to HDR, HDR to DATA.
  - DATA to CSUM after the last payload symbol, or to IDLE if `CHECKSUM_EN`=0.
  - CSUM to IDLE.
- Every transition out of SYNC/HDR/DATA/CSUM happens only when the hold counter reaches `HOLD_CYCLES`-1.
- Symbol order:
  - `SYNC_SYM`
  - header = `mode` zero-extended to `OUT_W`
  - word 0 MSB symbol first through word `NUM_WORDS`-1 LSB symbol
  - checksum = XOR of the header and all payload symbols (sync excluded)
- Frame length = 2 + `NUM_WORDS*WORD_W/OUT_W` + `CHECKSUM_EN` symbols. This is 11 at the defaults.
- `mode` and `words` are registered at start. Later input changes do not affect the frame in flight.
- `start` while not IDLE: ignored and `err_drop` set. The current frame is unaffected.
- `ena`=0: FSM, counters, capture registers and outputs hold their values, and `done` holds its value. Operation resumes exactly where it stopped when `ena`=1.
- Outside frames: `out_sym`=0 and `out_valid`=0.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `out_sym`=0, `out_valid`=0, `frame_first`=0, `done`=0, `err_drop`=0, FSM=IDLE.
- Asserting `rst_n` mid-frame aborts the frame immediately. No `done` is issued and `err_drop` is cleared.
- `start` sampled at edge k (IDLE, `ena`=1):
  - from k+1: `busy`=1 and the sync symbol with `out_valid`=1 and `frame_first`=1
  - each symbol then lasts `HOLD_CYCLES` cycles
- After the last symbol's hold: FSM returns to IDLE with `busy`=0, `out_valid`=0 and `done`=1 for exactly that one cycle.
- A `start` during the `done` cycle is accepted, giving a minimum inter-frame gap of 1 cycle.
- Total frame time = frame length × `HOLD_CYCLES` cycles, plus 1 cycle for `done`.
- The hold counter is `$clog2(HOLD_CYCLES)` bits, minimum 1, and wraps to 0 at each symbol advance.
- The payload index runs 0 to `NUM_WORDS*WORD_W/OUT_W`-1 with no wrap.

## Structure
- Package `result_serializer_pkg`:
  - state enum
  - default `SYNC_SYM`
  - a function returning the frame length from the parameters
- One sub-module, `frame_sym_sel`: a combinational select of payload symbol i from the captured word vector (MSB-first within each word).
- Elaboration-time assertions cover the `WORD_W % OUT_W`, `MODE_W <= OUT_W` and `HOLD_CYCLES >= 1` rules.

## Test plan
- Checksum frame:
  - Stimulus: defaults; `mode`=3'b101, word0=0x12345678, word1=0xDEADBEEF; start pulse.
  - Response: symbols A5,05,12,34,56,78,DE,AD,BE,EF,2F on 11 consecutive cycles; `frame_first` on A5 only; `done` 1 cycle after 2F.
- Hold cycles:
  - Stimulus: `HOLD_CYCLES`=3, `CHECKSUM_EN`=0, same data.
  - Response: each of the 10 symbols is stable for 3 cycles; `busy` is high for 30 cycles.
- Busy start and capture:
  - Stimulus: start again mid-frame, and change `words` after start.
  - Response: frame unchanged; `err_drop`=1 and stays high until reset.
- Back-to-back frames:
  - Stimulus: start asserted during the `done` cycle.
  - Response: next sync appears the following cycle, with exactly one `out_valid`=0 cycle between frames.
- Stall:
  - Stimulus: `ena`=0 for 5 cycles during symbol 0x56.
  - Response: 0x56 held throughout the stall; the sequence then continues with 0x78.
- Reset abort:
  - Stimulus: `rst_n` low during the DATA state.
  - Response: all outputs 0 immediately; no `done`; a fresh start afterwards yields a complete, correct frame.

Source files
------------

// File: rtl/result_serializer_pkg.sv
// result_serializer_pkg
//   Shared definitions for the result serializer:
//   - state_t          : frame FSM state encoding
//   - DEFAULT_SYNC_SYM : default first symbol of every frame
//   - frame_len()      : symbols per frame for a given parameter set
package result_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_HDR  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_SYM = 8'hA5;

  // sync + header + payload symbols + optional checksum
  function automatic int frame_len(input int word_w, input int num_words,
                                   input int out_w, input int checksum_en);
    return 2 + (num_words * word_w) / out_w + checksum_en;
  endfunction

endpackage

// File: rtl/result_serializer_if.sv
// result_serializer_if
//   Groups the request side (ena, start, mode, words) and the pin-bus side
//   (busy, out_sym, out_valid, frame_first, done, err_drop) of the serializer.
//   master : the block requesting frames and watching the bus (core / bench)
//   slave  : the serializer itself
interface result_serializer_if #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 2,
  parameter int OUT_W     = 8,
  parameter int MODE_W    = 3
);

  logic                          ena;
  logic                          start;
  logic [MODE_W-1:0]             mode;
  logic [NUM_WORDS*WORD_W-1:0]   words;
  logic                          busy;
  logic [OUT_W-1:0]              out_sym;
  logic                          out_valid;
  logic                          frame_first;
  logic                          done;
  logic                          err_drop;

  modport master (
    output ena, start, mode, words,
    input  busy, out_sym, out_valid, frame_first, done, err_drop
  );

  modport slave (
    input  ena, start, mode, words,
    output busy, out_sym, out_valid, frame_first, done, err_drop
  );

endinterface

// File: rtl/result_serializer_frame_sym_sel.sv
// frame_sym_sel
//   Combinational pick of payload symbol idx from the captured word vector.
//   Symbols are numbered word 0 first, MSB symbol first within each word.
//   Ports:
//     words : packed payload, word 0 in the LSBs
//     idx   : payload symbol index
//     sym   : selected OUT_W-bit symbol (0 for indices past the payload)
module frame_sym_sel #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 2,
  parameter int OUT_W     = 8,
  parameter int IDX_W     = 3
) (
  input  logic [NUM_WORDS*WORD_W-1:0] words,
  input  logic [IDX_W-1:0]            idx,
  output logic [OUT_W-1:0]            sym
);

  localparam int SPW  = WORD_W / OUT_W;
  localparam int NSYM = NUM_WORDS * SPW;

  // Table padded to a power of two so any idx value selects something defined
  logic [OUT_W-1:0] sym_tab [2**IDX_W];

  genvar gi;
  for (gi = 0; gi < 2**IDX_W; gi++) begin : g_sym
    if (gi < NSYM) begin : g_live
      localparam int LSB = (gi / SPW) * WORD_W + (SPW - 1 - (gi % SPW)) * OUT_W;
      assign sym_tab[gi] = words[LSB +: OUT_W];
    end else begin : g_pad
      assign sym_tab[gi] = '0;
    end
  end

  assign sym = sym_tab[idx];

endmodule

// File: rtl/result_serializer.sv
// result_serializer
//   Captures NUM_WORDS result words plus a mode tag on start and streams them
//   as a framed packet: sync, header, payload (MSB-first), optional XOR
//   checksum. Each symbol is held for HOLD_CYCLES cycles. All outputs are
//   registered; ena=0 freezes every register, including done.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset; aborts a frame in flight
//     bus   : slave side of result_serializer_if (request inputs, pin outputs)
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int              WORD_W      = 32,
  parameter int              NUM_WORDS   = 2,
  parameter int              OUT_W       = 8,
  parameter int              MODE_W      = 3,
  parameter int              HOLD_CYCLES = 1,
  parameter bit              CHECKSUM_EN = 1'b1,
  parameter logic [OUT_W-1:0] SYNC_SYM   = OUT_W'(DEFAULT_SYNC_SYM)
) (
  input logic               clk,
  input logic               rst_n,
  result_serializer_if.slave bus
);

  localparam int NSYM   = NUM_WORDS * WORD_W / OUT_W;
  localparam int IDX_W  = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NSYM - 1);

  if (WORD_W % OUT_W != 0) begin : g_bad_word_w
    $error("WORD_W must be a multiple of OUT_W");
  end
  if (MODE_W > OUT_W) begin : g_bad_mode_w
    $error("MODE_W must not exceed OUT_W");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end

  state_t                      state_reg, state_next;
  logic [HOLD_W-1:0]           hold_reg, hold_next;
  logic [IDX_W-1:0]            idx_reg, idx_next;
  logic [OUT_W-1:0]            csum_reg, csum_next;
  logic [MODE_W-1:0]           mode_reg, mode_next;
  logic [NUM_WORDS*WORD_W-1:0] words_reg, words_next;
  logic                        busy_reg, busy_next;
  logic [OUT_W-1:0]            out_sym_reg, out_sym_next;
  logic                        out_valid_reg, out_valid_next;
  logic                        first_reg, first_next;
  logic                        done_reg, done_next;
  logic                        err_reg, err_next;

  logic [IDX_W-1:0]            sel_idx;
  logic [OUT_W-1:0]            sel_sym;
  logic [OUT_W-1:0]            hdr_sym;

  // The selector looks up the symbol about to be loaded: payload 0 when
  // leaving the header, otherwise the one after the current index.
  assign sel_idx = (state_reg == ST_DATA) ? idx_reg + 1'b1 : '0;
  assign hdr_sym = OUT_W'(mode_reg);

  frame_sym_sel #(
    .WORD_W   (WORD_W),
    .NUM_WORDS(NUM_WORDS),
    .OUT_W    (OUT_W),
    .IDX_W    (IDX_W)
  ) u_sel (
    .words(words_reg),
    .idx  (sel_idx),
    .sym  (sel_sym)
  );

  always_comb begin
    state_next     = state_reg;
    hold_next      = hold_reg;
    idx_next       = idx_reg;
    csum_next      = csum_reg;
    mode_next      = mode_reg;
    words_next     = words_reg;
    busy_next      = busy_reg;
    out_sym_next   = out_sym_reg;
    out_valid_next = out_valid_reg;
    first_next     = first_reg;
    done_next      = 1'b0;
    err_next       = err_reg;

    if (state_reg == ST_IDLE) begin
      busy_next      = 1'b0;
      out_sym_next   = '0;
      out_valid_next = 1'b0;
      first_next     = 1'b0;
      if (bus.start) begin
        state_next     = ST_SYNC;
        mode_next      = bus.mode;
        words_next     = bus.words;
        hold_next      = '0;
        idx_next       = '0;
        csum_next      = '0;
        busy_next      = 1'b1;
        out_sym_next   = SYNC_SYM;
        out_valid_next = 1'b1;
        first_next     = 1'b1;
      end
    end else begin
      if (bus.start) begin
        err_next = 1'b1;
      end
      if (hold_reg != HOLD_LAST) begin
        hold_next = hold_reg + 1'b1;
      end else begin
        hold_next = '0;
        unique case (state_reg)
          ST_SYNC: begin
            state_next   = ST_HDR;
            out_sym_next = hdr_sym;
            first_next   = 1'b0;
            csum_next    = hdr_sym;
          end
          ST_HDR: begin
            state_next   = ST_DATA;
            idx_next     = '0;
            out_sym_next = sel_sym;
            csum_next    = csum_reg ^ sel_sym;
          end
          ST_DATA: begin
            if (idx_reg != IDX_LAST) begin
              idx_next     = idx_reg + 1'b1;
              out_sym_next = sel_sym;
              csum_next    = csum_reg ^ sel_sym;
            end else if (CHECKSUM_EN) begin
              state_next   = ST_CSUM;
              out_sym_next = csum_reg;
            end else begin
              state_next     = ST_IDLE;
              busy_next      = 1'b0;
              out_sym_next   = '0;
              out_valid_next = 1'b0;
              done_next      = 1'b1;
            end
          end
          default: begin
            // ST_CSUM, and a safe landing for any unused encoding
            state_next     = ST_IDLE;
            busy_next      = 1'b0;
            out_sym_next   = '0;
            out_valid_next = 1'b0;
            first_next     = 1'b0;
            done_next      = (state_reg == ST_CSUM);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      hold_reg      <= '0;
      idx_reg       <= '0;
      csum_reg      <= '0;
      mode_reg      <= '0;
      words_reg     <= '0;
      busy_reg      <= 1'b0;
      out_sym_reg   <= '0;
      out_valid_reg <= 1'b0;
      first_reg     <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else if (bus.ena) begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      idx_reg       <= idx_next;
      csum_reg      <= csum_next;
      mode_reg      <= mode_next;
      words_reg     <= words_next;
      busy_reg      <= busy_next;
      out_sym_reg   <= out_sym_next;
      out_valid_reg <= out_valid_next;
      first_reg     <= first_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.out_sym     = out_sym_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.frame_first = first_reg;
  assign bus.done        = done_reg;
  assign bus.err_drop    = err_reg;

endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer
//   Two serializers: u_a at defaults (hold 1, checksum on) and u_b with
//   hold 3 and no checksum. Expected frames come from a queue-based model
//   built straight from the framing rules.
module tb_result_serializer;
  import result_serializer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  result_serializer_if if_a ();
  result_serializer_if if_b ();

  result_serializer #(.HOLD_CYCLES(1), .CHECKSUM_EN(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
  );
  result_serializer #(.HOLD_CYCLES(3), .CHECKSUM_EN(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csum;
  } vec_t;
  vec_t tbl[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic st, input logic [2:0] m, input logic [63:0] w);
    if (sel == 0) begin
      if_a.start = st; if_a.mode = m; if_a.words = w;
    end else begin
      if_b.start = st; if_b.mode = m; if_b.words = w;
    end
  endtask

  task automatic set_start(input int sel, input logic st);
    if (sel == 0) if_a.start = st;
    else          if_b.start = st;
  endtask

  task automatic set_ena(input int sel, input logic e);
    if (sel == 0) if_a.ena = e;
    else          if_b.ena = e;
  endtask

  // {busy, out_valid, frame_first, done, out_sym}
  task automatic get_out(input int sel, output logic [11:0] v, output logic err);
    if (sel == 0) begin
      v = {if_a.busy, if_a.out_valid, if_a.frame_first, if_a.done, if_a.out_sym};
      err = if_a.err_drop;
    end else begin
      v = {if_b.busy, if_b.out_valid, if_b.frame_first, if_b.done, if_b.out_sym};
      err = if_b.err_drop;
    end
  endtask

  // Reference frame: sync, header, bytes of each word MSB-first, XOR checksum
  task automatic model_frame(input logic [2:0] m, input logic [63:0] w, input bit ce);
    logic [7:0] c, s;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    c = {5'b0, m};
    exp_q.push_back(c);
    for (int wi = 0; wi < 2; wi++) begin
      for (int b = 3; b >= 0; b--) begin
        s = 8'(w >> (wi * 32 + b * 8));
        exp_q.push_back(s);
        c ^= s;
      end
    end
    if (ce) exp_q.push_back(c);
  endtask

  // Issues start now and checks every cycle of the frame. Returns at the
  // done cycle (a start driven right after this is a back-to-back frame).
  task automatic run_frame(input int sel, input logic [2:0] m, input logic [63:0] w,
                           input int stall_idx, input int stall_len, input int disturb_idx,
                           output logic [7:0] last, output int busy_cnt);
    int hold;
    logic [11:0] v, e;
    logic err;
    hold = (sel == 0) ? 1 : 3;
    model_frame(m, w, sel == 0);
    set_in(sel, 1'b1, m, w);
    step();
    set_start(sel, 1'b0);
    busy_cnt = 0;
    last = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      for (int h = 0; h < hold; h++) begin
        get_out(sel, v, err);
        e = {1'b1, 1'b1, (i == 0), 1'b0, exp_q[i]};
        chk($sformatf("dut%0d sym%0d hold%0d", sel, i, h), 32'(v), 32'(e));
        busy_cnt += int'(v[11]);
        last = v[7:0];
        if (i == disturb_idx && h == 0) begin
          set_in(sel, 1'b1, m ^ 3'b111, {$urandom, $urandom});
        end
        if (i == stall_idx && h == 0) begin
          set_ena(sel, 1'b0);
          for (int s = 0; s < stall_len; s++) begin
            step();
            get_out(sel, v, err);
            chk($sformatf("dut%0d stall sym%0d", sel, i), 32'(v), 32'(e));
          end
          set_ena(sel, 1'b1);
        end
        step();
        set_start(sel, 1'b0);
      end
    end
    get_out(sel, v, err);
    chk($sformatf("dut%0d done", sel), 32'(v), 32'h100);
    $display("frame dut=%0d mode=%0d words=%h last_sym=%h err_drop=%0b", sel, m, w, last, err);
  endtask

  initial begin
    logic [11:0] v;
    logic err;
    logic [7:0] last;
    int bc;
    logic [63:0] spec_w;
    spec_w = {32'hDEADBEEF, 32'h12345678};

    tbl[0] = '{3'b101, 32'h12345678, 32'hDEADBEEF, 8'h2F};
    tbl[1] = '{3'b000, 32'h00000000, 32'h00000000, 8'h00};
    tbl[2] = '{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h07};
    tbl[3] = '{3'b001, 32'h01020304, 32'h05060708, 8'h09};

    if_a.ena = 1'b1; if_b.ena = 1'b1;
    set_in(0, 1'b0, '0, '0);
    set_in(1, 1'b0, '0, '0);

    // Reset state
    repeat (3) step();
    for (int s = 0; s < 2; s++) begin
      get_out(s, v, err);
      chk($sformatf("reset out dut%0d", s), 32'(v), 32'h0);
      chk($sformatf("reset err dut%0d", s), 32'(err), 32'h0);
    end
    rst_n = 1'b1;
    step();

    // Table-driven frames on the default instance
    for (int t = 0; t < 4; t++) begin
      run_frame(0, tbl[t].mode, {tbl[t].w1, tbl[t].w0}, -1, 0, -1, last, bc);
      chk($sformatf("tbl%0d checksum", t), 32'(last), 32'(tbl[t].csum));
      step();
      get_out(0, v, err);
      chk($sformatf("tbl%0d idle", t), 32'(v), 32'h0);
      step();
    end

    // Hold cycles = 3, no checksum
    run_frame(1, 3'b101, spec_w, -1, 0, -1, last, bc);
    chk("hold3 busy cycles", 32'(bc), 32'd30);
    chk("hold3 last sym", 32'(last), 32'hEF);
    step();

    // Start while busy plus input change after capture
    get_out(0, v, err);
    chk("err_drop before", 32'(err), 32'h0);
    run_frame(0, 3'b101, spec_w, -1, 0, 3, last, bc);
    get_out(0, v, err);
    chk("err_drop set", 32'(err), 32'h1);
    repeat (3) step();
    get_out(0, v, err);
    chk("err_drop sticky", 32'(err), 32'h1);

    // Back-to-back: second start during the first frame's done cycle
    run_frame(0, 3'b010, spec_w, -1, 0, -1, last, bc);
    run_frame(0, 3'b101, {32'hCAFEF00D, 32'h0BADBEEF}, -1, 0, -1, last, bc);
    step();

    // Stall during 0x56
    run_frame(0, 3'b101, spec_w, 4, 5, -1, last, bc);

    // done holds while ena=0
    set_ena(0, 1'b0);
    step();
    get_out(0, v, err);
    chk("done held by ena", 32'(v), 32'h100);
    set_ena(0, 1'b1);
    step();
    get_out(0, v, err);
    chk("done released", 32'(v), 32'h0);

    // Reset abort mid-DATA
    set_in(0, 1'b1, 3'b101, spec_w);
    step();
    set_start(0, 1'b0);
    repeat (5) step();
    get_out(0, v, err);
    chk("pre-abort in data", 32'(v[11:10]), 32'h3);
    rst_n = 1'b0;
    #1;
    get_out(0, v, err);
    chk("abort out", 32'(v), 32'h0);
    chk("abort err cleared", 32'(err), 32'h0);
    for (int s = 0; s < 3; s++) begin
      step();
      get_out(0, v, err);
      chk("abort no done", 32'({err, v}), 32'h0);
    end
    rst_n = 1'b1;
    step();
    run_frame(0, 3'b101, spec_w, -1, 0, -1, last, bc);
    chk("post-abort checksum", 32'(last), 32'h2F);
    step();

    // Randomized frames against the model
    for (int k = 0; k < 30; k++) begin
      int sel, sidx, slen, gap;
      logic [2:0] m;
      logic [63:0] w;
      sel = int'($urandom_range(0, 1));
      m = 3'($urandom);
      w = {$urandom, $urandom};
      sidx = -1;
      slen = 0;
      if ($urandom_range(0, 3) == 0) begin
        sidx = int'($urandom_range(0, 9));
        slen = int'($urandom_range(1, 4));
      end
      run_frame(sel, m, w, sidx, slen, -1, last, bc);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        step();
        get_out(sel, v, err);
        chk($sformatf("rand%0d idle", k), 32'(v), 32'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
